// File: rtl/branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// branch_resolution_unit
//
// Back end of the dynamic branch prediction path. Fetch pushes each predicted
// branch into an in-order queue. When EX resolves the oldest branch, the head
// entry is compared against the actual outcome. The unit then trains the
// predictor and, on a misprediction, flushes the front end and redirects it.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   pred_*              predicted branch issued by fetch (pc, dir, target, pc+1)
//   res_*               resolution of the oldest in-flight branch (dir, target)
//   full, empty         queue occupancy, derived from the registered count
//   upd_branch/taken/pc one-cycle training strobe and payload for the predictor
//   flush, redirect_pc  one-cycle mispredict flush and the corrected fetch PC
//   branch_count        resolved branches (saturating)
//   mispredict_count    mispredicted branches (saturating)
//   overflow_err        sticky: prediction offered while the queue was full
//   underflow_err       sticky: resolution offered while the queue was empty
// -----------------------------------------------------------------------------
module branch_resolution_unit #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_target,
  input  logic [PC_W-1:0]  pred_fallthrough,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             full,
  output logic             empty,
  output logic             upd_branch,
  output logic             upd_taken,
  output logic [PC_W-1:0]  upd_pc,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Queue storage, one array per entry field.
  logic [PC_W-1:0]  q_pc          [DEPTH];
  logic             q_taken       [DEPTH];
  logic [PC_W-1:0]  q_target      [DEPTH];
  logic [PC_W-1:0]  q_fallthrough [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Head entry and decisions for this cycle.
  logic             do_res;
  logic             mispredict;
  logic             do_enq;
  logic             drop_pred;
  logic [PC_W-1:0]  head_pc;
  logic             head_taken;
  logic [PC_W-1:0]  head_target;
  logic [PC_W-1:0]  head_fallthrough;

  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);

  assign head_pc          = q_pc[rd_ptr];
  assign head_taken       = q_taken[rd_ptr];
  assign head_target      = q_target[rd_ptr];
  assign head_fallthrough = q_fallthrough[rd_ptr];

  // NOTE: every signal assigned in always_comb gets a default at the top so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    do_res     = 1'b0;
    mispredict = 1'b0;
    do_enq     = 1'b0;
    drop_pred  = 1'b0;

    do_res = res_valid && !empty;
    if (do_res) begin
      mispredict = (res_taken != head_taken) ||
                   (res_taken && head_taken && (res_target != head_target));
    end

    // A mispredict kills everything younger, including a branch fetched in the
    // same cycle: that one is wrong-path too, so it is dropped silently.
    drop_pred = do_res && mispredict;
    do_enq    = pred_valid && !full && !drop_pred;
  end

  // NOTE: the queue payload has no reset. Validity is carried entirely by
  // count and the pointers, so clearing them discards every entry; resetting
  // the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      q_pc[wr_ptr]          <= pred_pc;
      q_taken[wr_ptr]       <= pred_taken;
      q_target[wr_ptr]      <= pred_target;
      q_fallthrough[wr_ptr] <= pred_fallthrough;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (drop_pred) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_res) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_enq && !do_res)      count <= count + COUNT_ONE;
      else if (do_res && !do_enq) count <= count - COUNT_ONE;
    end
  end

  // Training strobe and flush/redirect, all produced on the resolving edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_branch  <= 1'b0;
      upd_taken   <= 1'b0;
      upd_pc      <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_branch <= do_res;
      flush      <= do_res && mispredict;
      if (do_res) begin
        upd_taken <= res_taken;
        upd_pc    <= head_pc;
      end
      // redirect_pc holds between flushes.
      if (do_res && mispredict) begin
        redirect_pc <= res_taken ? res_target : head_fallthrough;
      end
    end
  end

  // Statistics and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
    end else begin
      if (do_res && (branch_count != CNT_MAX)) begin
        branch_count <= branch_count + CNT_ONE;
      end
      if (do_res && mispredict && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + CNT_ONE;
      end
      if (pred_valid && full && !drop_pred) overflow_err  <= 1'b1;
      if (res_valid && empty)               underflow_err <= 1'b1;
    end
  end

endmodule
